// File: rtl/fft_pkg.sv
// Shared types and butterfly index math for the in-place radix-2 DIT FFT sequencer.
// bfly_idx works on 32-bit values so it serves any transform size up to 2**31 points.
package fft_pkg;

   localparam int unsigned FFT_L = 11;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StDrain,
      StDone
   } state_t;

   typedef struct packed {
      logic [31:0] ia;
      logic [31:0] ib;
      logic [31:0] tw;
   } bfly_t;

   // Upper index gets a zero inserted at bit s; lower index sets that bit.
   // Twiddle exponent is the low s bits of i scaled to the N/2-entry ROM.
   function automatic bfly_t bfly_idx(input int unsigned l, input int unsigned s,
                                      input int unsigned i);
      logic [31:0] low_mask;
      logic [31:0] ia;
      bfly_t       r;
      low_mask = (32'd1 << s) - 32'd1;
      ia       = ((i & ~low_mask) << 1) | (i & low_mask);
      r.ia     = ia;
      r.ib     = ia | (32'd1 << s);
      r.tw     = (i & low_mask) << (l - 1 - s);
      return r;
   endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational butterfly address generator: (stage, butterfly index) -> (ia, ib, tw).
module fft_addr_gen
   import fft_pkg::*;
#(
   parameter int unsigned L   = FFT_L,
   localparam int unsigned SW = $clog2(L)
) (
   input  logic [SW-1:0] s_i,
   input  logic [L-2:0]  idx_i,
   output logic [L-1:0]  ia_o,
   output logic [L-1:0]  ib_o,
   output logic [L-2:0]  tw_o
);

   bfly_t r;
   logic  unused_hi;

   always_comb begin
      r = bfly_idx(L, 32'(s_i), 32'(idx_i));
   end

   assign ia_o = r.ia[L-1:0];
   assign ib_o = r.ib[L-1:0];
   assign tw_o = r.tw[L-2:0];

   // Bits above the transform width are always zero for legal (s, i).
   assign unused_hi = ^{r.ia[31:L], r.ib[31:L], r.tw[31:L-1]};

endmodule

// File: rtl/fft_stage_sequencer.sv
// Drives the butterfly unit through all L stages of an N=2**L in-place DIT FFT, draining the
// write-back delay line between stages so a stage never reads a location still in flight.
module fft_stage_sequencer
   import fft_pkg::*;
#(
   parameter int unsigned L       = FFT_L,
   parameter int unsigned BFU_LAT = 2,
   localparam int unsigned SW     = $clog2(L)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   input  logic          abort,
   input  logic          stall,
   output logic          rd_en,
   output logic [L-1:0]  rd_addr_a,
   output logic [L-1:0]  rd_addr_b,
   output logic [L-2:0]  tw_addr,
   output logic          wr_en,
   output logic [L-1:0]  wr_addr_a,
   output logic [L-1:0]  wr_addr_b,
   output logic [SW-1:0] stage,
   output logic          busy,
   output logic          done
);

   localparam int unsigned PW  = 2 * L + 1;
   localparam int unsigned DCW = (BFU_LAT > 1) ? $clog2(BFU_LAT) : 1;

   localparam logic [L-2:0]   IdxLast   = '1;
   localparam logic [SW-1:0]  StageLast = SW'(L - 1);
   localparam logic [DCW-1:0] DrainLast = DCW'(BFU_LAT - 1);

   state_t         state_q, state_d;
   logic [SW-1:0]  s_q, s_d;
   logic [L-2:0]   idx_q, idx_d;
   logic [DCW-1:0] drain_cnt_q, drain_cnt_d;
   logic           done_q, done_d;

   logic           rd_en_q, rd_en_d;
   logic [L-1:0]   rd_a_q, rd_a_d;
   logic [L-1:0]   rd_b_q, rd_b_d;
   logic [L-2:0]   tw_q, tw_d;

   // Each entry is {valid, addr_a, addr_b}; the last entry is the write port.
   logic [PW-1:0]  pipe_q [BFU_LAT];
   logic [PW-1:0]  pipe_d [BFU_LAT];

   logic [L-1:0]   ia, ib;
   logic [L-2:0]   tw;

   fft_addr_gen #(
      .L(L)
   ) u_addr_gen (
      .s_i  (s_q),
      .idx_i(idx_q),
      .ia_o (ia),
      .ib_o (ib),
      .tw_o (tw)
   );

   always_comb begin
      state_d     = state_q;
      s_d         = s_q;
      idx_d       = idx_q;
      drain_cnt_d = drain_cnt_q;
      done_d      = 1'b0;
      rd_en_d     = rd_en_q;
      rd_a_d      = rd_a_q;
      rd_b_d      = rd_b_q;
      tw_d        = tw_q;
      pipe_d      = pipe_q;

      if (abort && (state_q != StIdle)) begin
         state_d     = StIdle;
         s_d         = '0;
         idx_d       = '0;
         drain_cnt_d = '0;
         rd_en_d     = 1'b0;
         for (int k = 0; k < BFU_LAT; k++) begin
            pipe_d[k] = '0;
         end
      end else if (state_q == StIdle) begin
         if (start && !abort) begin
            state_d     = StIssue;
            s_d         = '0;
            idx_d       = '0;
            drain_cnt_d = '0;
         end
      end else if (!stall) begin
         // A stall freezes the issue register, the delay line and the FSM together, so
         // the whole schedule simply slides by the number of stalled cycles.
         pipe_d[0] = {rd_en_q, rd_a_q, rd_b_q};
         for (int k = 1; k < BFU_LAT; k++) begin
            pipe_d[k] = pipe_q[k-1];
         end
         rd_en_d = 1'b0;

         unique case (state_q)
            StIssue: begin
               rd_en_d = 1'b1;
               rd_a_d  = ia;
               rd_b_d  = ib;
               tw_d    = tw;
               idx_d   = idx_q + (L-1)'(1);
               if (idx_q == IdxLast) begin
                  state_d     = StDrain;
                  drain_cnt_d = '0;
               end
            end
            StDrain: begin
               if (drain_cnt_q == DrainLast) begin
                  if (s_q == StageLast) begin
                     state_d = StDone;
                  end else begin
                     state_d = StIssue;
                     s_d     = s_q + SW'(1);
                     idx_d   = '0;
                  end
               end else begin
                  drain_cnt_d = drain_cnt_q + DCW'(1);
               end
            end
            StDone: begin
               state_d = StIdle;
               s_d     = '0;
               done_d  = 1'b1;
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         s_q         <= '0;
         idx_q       <= '0;
         drain_cnt_q <= '0;
         done_q      <= 1'b0;
         rd_en_q     <= 1'b0;
         rd_a_q      <= '0;
         rd_b_q      <= '0;
         tw_q        <= '0;
         for (int k = 0; k < BFU_LAT; k++) begin
            pipe_q[k] <= '0;
         end
      end else begin
         state_q     <= state_d;
         s_q         <= s_d;
         idx_q       <= idx_d;
         drain_cnt_q <= drain_cnt_d;
         done_q      <= done_d;
         rd_en_q     <= rd_en_d;
         rd_a_q      <= rd_a_d;
         rd_b_q      <= rd_b_d;
         tw_q        <= tw_d;
         for (int k = 0; k < BFU_LAT; k++) begin
            pipe_q[k] <= pipe_d[k];
         end
      end
   end

   assign rd_en     = rd_en_q & ~stall;
   assign rd_addr_a = rd_a_q;
   assign rd_addr_b = rd_b_q;
   assign tw_addr   = tw_q;
   assign wr_en     = pipe_q[BFU_LAT-1][PW-1] & ~stall;
   assign wr_addr_a = pipe_q[BFU_LAT-1][2*L-1:L];
   assign wr_addr_b = pipe_q[BFU_LAT-1][L-1:0];
   assign stage     = s_q;
   assign busy      = (state_q == StIssue) || (state_q == StDrain);
   assign done      = done_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench: stimulus queues expected reads/writes/done with their cycle offsets from
// start; a negedge monitor pops and compares whenever the sequencer presents an event.
module tb_fft_stage_sequencer;

   localparam int unsigned L   = 3;
   localparam int unsigned LAT = 2;
   localparam int unsigned SW  = 2;
   localparam int          NH  = 4;
   localparam int          PER = NH + LAT;
   localparam int unsigned BL  = 11;

   typedef struct {
      int rel;
      int a;
      int b;
      int tw;
      int st;
   } ev_t;

   logic          clk = 1'b0;
   logic          reset_n, start, abort, stall;
   logic          rd_en, wr_en, busy, done;
   logic [L-1:0]  rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
   logic [L-2:0]  tw_addr;
   logic [SW-1:0] stage;
   logic [19:0]   outs;

   logic          b_start, b_rd_en, b_wr_en, b_busy, b_done;
   logic [BL-1:0] b_rd_a, b_rd_b, b_wr_a, b_wr_b;
   logic [BL-2:0] b_tw;
   logic [3:0]    b_stage;

   int  cyc = 0;
   int  start_cyc = 0;
   int  checks = 0;
   int  errors = 0;
   bit  mon_on = 1'b0;
   int  mrel;
   ev_t me;
   ev_t rd_exp[$];
   ev_t wr_exp[$];
   int  done_exp[$];

   // Hand-computed (a, b, tw) for L=3, stage-major then butterfly index.
   int  tab_a[12]  = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
   int  tab_b[12]  = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
   int  tab_tw[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

   int  b_start_cyc = 0;
   int  b_rd_cnt = 0;
   int  b_wr_cnt = 0;
   int  b_done_rel = -1;
   bit  b_on = 1'b0;

   fft_stage_sequencer #(
      .L      (L),
      .BFU_LAT(LAT)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .abort    (abort),
      .stall    (stall),
      .rd_en    (rd_en),
      .rd_addr_a(rd_addr_a),
      .rd_addr_b(rd_addr_b),
      .tw_addr  (tw_addr),
      .wr_en    (wr_en),
      .wr_addr_a(wr_addr_a),
      .wr_addr_b(wr_addr_b),
      .stage    (stage),
      .busy     (busy),
      .done     (done)
   );

   fft_stage_sequencer #(
      .L      (BL),
      .BFU_LAT(LAT)
   ) dut_big (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (b_start),
      .abort    (1'b0),
      .stall    (1'b0),
      .rd_en    (b_rd_en),
      .rd_addr_a(b_rd_a),
      .rd_addr_b(b_rd_b),
      .tw_addr  (b_tw),
      .wr_en    (b_wr_en),
      .wr_addr_a(b_wr_a),
      .wr_addr_b(b_wr_b),
      .stage    (b_stage),
      .busy     (b_busy),
      .done     (b_done)
   );

   assign outs = {rd_en, rd_addr_a, rd_addr_b, tw_addr, wr_en, wr_addr_a, wr_addr_b, stage,
                  busy, done};

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   function automatic int slide(input int e, input int sa, input int sl);
      return (e >= sa) ? e + sl : e;
   endfunction

   // Queue the expected schedule; events after rel 'last' are cut off by abort/reset.
   task automatic plan(input int sa, input int sl, input int last);
      ev_t ev;
      int  r;
      for (int s = 0; s < int'(L); s++) begin
         for (int i = 0; i < NH; i++) begin
            r     = s * PER + i + 2;
            ev.a  = tab_a[s*NH+i];
            ev.b  = tab_b[s*NH+i];
            ev.tw = tab_tw[s*NH+i];
            ev.st = s;
            ev.rel = slide(r, sa, sl);
            if (ev.rel <= last) rd_exp.push_back(ev);
            ev.rel = slide(r + int'(LAT), sa, sl);
            if (ev.rel <= last) wr_exp.push_back(ev);
         end
      end
      r = slide(int'(L) * PER + 2, sa, sl);
      if (r <= last) done_exp.push_back(r);
   endtask

   task automatic start_run();
      @(posedge clk);
      #1;
      start     = 1'b1;
      start_cyc = cyc;
      mon_on    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_rel(input int r);
      while (cyc - start_cyc < r) begin
         @(posedge clk);
         #3;
      end
   endtask

   task automatic finish_test(input string name);
      repeat (3) @(posedge clk);
      #3;
      chk({name, "_rd_left"}, rd_exp.size(), 0);
      chk({name, "_wr_left"}, wr_exp.size(), 0);
      chk({name, "_done_left"}, done_exp.size(), 0);
      mon_on = 1'b0;
      rd_exp.delete();
      wr_exp.delete();
      done_exp.delete();
   endtask

   always @(negedge clk) begin
      if (mon_on && reset_n) begin
         mrel = cyc - start_cyc;
         if (rd_en) begin
            checks++;
            if (rd_exp.size() == 0) begin
               errors++;
               $display("FAIL rd_unexpected: rel %0d a=%0d b=%0d, expected no read", mrel,
                        rd_addr_a, rd_addr_b);
            end else begin
               me = rd_exp.pop_front();
               if (mrel != me.rel || int'(rd_addr_a) != me.a || int'(rd_addr_b) != me.b ||
                   int'(tw_addr) != me.tw || int'(stage) != me.st) begin
                  errors++;
                  $display("FAIL rd_entry: got rel %0d a=%0d b=%0d tw=%0d s=%0d, expected rel %0d a=%0d b=%0d tw=%0d s=%0d",
                           mrel, rd_addr_a, rd_addr_b, tw_addr, stage, me.rel, me.a, me.b,
                           me.tw, me.st);
               end
            end
         end
         if (wr_en) begin
            checks++;
            if (wr_exp.size() == 0) begin
               errors++;
               $display("FAIL wr_unexpected: rel %0d a=%0d b=%0d, expected no write", mrel,
                        wr_addr_a, wr_addr_b);
            end else begin
               me = wr_exp.pop_front();
               if (mrel != me.rel || int'(wr_addr_a) != me.a || int'(wr_addr_b) != me.b) begin
                  errors++;
                  $display("FAIL wr_entry: got rel %0d a=%0d b=%0d, expected rel %0d a=%0d b=%0d",
                           mrel, wr_addr_a, wr_addr_b, me.rel, me.a, me.b);
               end
            end
         end
         if (done) begin
            checks++;
            if (done_exp.size() == 0) begin
               errors++;
               $display("FAIL done_unexpected: rel %0d, expected no done", mrel);
            end else begin
               me.rel = done_exp.pop_front();
               if (mrel != me.rel) begin
                  errors++;
                  $display("FAIL done_cycle: got rel %0d, expected rel %0d", mrel, me.rel);
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (b_on) begin
         if (b_rd_en) b_rd_cnt++;
         if (b_wr_en) b_wr_cnt++;
         if (b_done && b_done_rel < 0) b_done_rel = cyc - b_start_cyc;
      end
   end

   initial begin
      reset_n = 1'b0;
      start   = 1'b0;
      abort   = 1'b0;
      stall   = 1'b0;
      b_start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", int'(outs), 0);
      reset_n = 1'b1;

      // Full unstalled transform; a start while busy must be ignored.
      plan(1000, 0, 1000);
      start_run();
      chk("busy_after_start", int'(busy), 1);
      wait_rel(5);
      start = 1'b1;
      wait_rel(6);
      start = 1'b0;
      wait_rel(21);
      chk("busy_after_done", int'(busy), 0);
      chk("done_one_cycle", int'(done), 0);
      finish_test("run");

      // Five-cycle stall starting at stage 1, i=2.
      plan(10, 5, 1000);
      start_run();
      wait_rel(10);
      stall = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("stall_rd_en", int'(rd_en), 0);
         chk("stall_wr_en", int'(wr_en), 0);
         @(posedge clk);
         #3;
      end
      stall = 1'b0;
      wait_rel(26);
      chk("stall_busy_end", int'(busy), 0);
      finish_test("stall");

      // Abort at stage 1, i=2, then a clean transform.
      plan(1000, 0, 10);
      start_run();
      wait_rel(10);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      chk("abort_busy", int'(busy), 0);
      chk("abort_wr_en", int'(wr_en), 0);
      wait_rel(24);
      finish_test("abort");
      plan(1000, 0, 1000);
      start_run();
      wait_rel(24);
      finish_test("after_abort");

      // Simultaneous start and abort in IDLE: stays idle.
      @(posedge clk);
      #1;
      start = 1'b1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      chk("start_abort_busy", int'(busy), 0);
      @(posedge clk);
      #1;
      chk("start_abort_rd_en", int'(rd_en), 0);

      // Asynchronous reset in stage 2.
      plan(1000, 0, 15);
      start_run();
      wait_rel(16);
      chk("pre_reset_busy", int'(busy), 1);
      reset_n = 1'b0;
      #1;
      chk("async_reset_outputs", int'(outs), 0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      finish_test("reset");

      // Full-size transform latency and pulse counts.
      @(posedge clk);
      #1;
      b_start     = 1'b1;
      b_start_cyc = cyc;
      b_on        = 1'b1;
      @(posedge clk);
      #1;
      b_start = 1'b0;
      while (b_done_rel < 0 && (cyc - b_start_cyc) < 12000) @(posedge clk);
      repeat (2) @(posedge clk);
      #1;
      chk("big_done_latency", b_done_rel, 11 * (1024 + 2) + 2);
      chk("big_rd_count", b_rd_cnt, 11 * 1024);
      chk("big_wr_count", b_wr_cnt, 11 * 1024);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
